fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter and sequencer for the `fifo_spram` TX FIFO. It shares the single FIFO write port between `N_REQ` producers, such as the CSR write path and the test-pattern generator. It bounds each owner to `MAX_BURST` consecutive words and drives a registered write strobe and data into the FIFO. It sits between the producers and the FIFO write side; the UART drains the FIFO independently.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `DATA_W`, default 32: word width, matches `word`.
- `MAX_BURST`, default 4: maximum words per grant, 1..255.
- `clk_i`  in  1  system clock; all state on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N_REQ  requester i holds a word.
- `req_data_i`  in  N_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W].
- `req_ready_o`  out  N_REQ  word of requester i accepted this cycle when valid&ready.
- `fifo_full_i`  in  1  FIFO has no free entry.
- `fifo_afull_i`  in  1  FIFO has at most one free entry.
- `fifo_wr_en_o`  out  1  registered FIFO write strobe.
- `fifo_wr_data_o`  out  DATA_W  registered FIFO write data.
- `busy_o`  out  1  state is GRANT.
- `owner_o`  out  $clog2(N_REQ)  current or last owner index.
- `wr_count_o`  out  16  total words written, wraps 0xFFFF→0.

## Operation
- State machine with two states: IDLE and GRANT.
- **IDLE**
  - All `req_ready_o` are 0.
  - If any `req_valid_i` is set: owner ← first valid index searching rr_ptr+1, rr_ptr+2, … modulo N_REQ; burst_cnt ← 0; go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `req_ready_o[owner]` = !stall. All other ready bits are 0.
  - stall = `fifo_full_i` | (`fifo_afull_i` & `fifo_wr_en_o`). The second term covers the registered write still in flight.
  - Transfer = `req_valid_i[owner]` & `req_ready_o[owner]`.
  - On transfer: `fifo_wr_en_o` ← 1, `fifo_wr_data_o` ← owner slice, burst_cnt+1, `wr_count_o`+1.
  - Exit to IDLE with rr_ptr ← owner when either:
    - a transfer occurs with burst_cnt == MAX_BURST-1; or
    - `req_valid_i[owner]` == 0.
  - A stall does not end the grant. The owner keeps the port while valid stays high.
- Each cycle without a transfer: `fifo_wr_en_o` ← 0; `fifo_wr_data_o` holds its last value.
- Producers must hold data stable while valid & !ready. Dropping valid before acceptance is permitted and ends the grant.
- burst_cnt is 8 bits.
- The arbiter never writes while `fifo_full_i` is high. `fifo_wr_en_o` never rises on a cycle following a stall decision.

## Timing
- Reset (reset_i low, asynchronous), until the first clk_i edge after release:
  - state IDLE, rr_ptr = N_REQ-1, so requester 0 wins first.
  - owner 0, burst_cnt 0.
  - `fifo_wr_en_o` 0, `fifo_wr_data_o` 0, `wr_count_o` 0, `busy_o` 0, all `req_ready_o` 0.
- Reset mid-burst aborts the burst. Any word already accepted but not yet written is discarded.
- Arbitration latency: valid rises at edge n; state is GRANT after edge n+1; earliest accept is the cycle after edge n+1.
- Write latency: transfer in cycle k gives `fifo_wr_en_o` = 1 during cycle k+1.
- Throughput: 1 word/cycle inside a burst. One IDLE bubble cycle between grants.
- Simultaneous valids: resolved strictly round-robin relative to rr_ptr. A single requester that stays valid is re-granted after the bubble.
- `wr_count_o` increments on the same edge that sets `fifo_wr_en_o`.

## Test plan
- Single requester, N_REQ=2, MAX_BURST=4. Req0 valid with data 0x42..0x47, six words, held continuously.
  - Expect writes 0x42..0x45, one bubble, then 0x46, 0x47.
  - Expect `wr_count_o`=6 and no write before cycle 2.
- Contention. Both valid continuously, req0 data 0xA0+i, req1 data 0xB0+i.
  - Expect FIFO order A0..A3, B0..B3, A4..A7, with one bubble between bursts.
- Backpressure. Req0 streaming; `fifo_afull_i` high during a write, then `fifo_full_i` high for 5 cycles.
  - Expect ready low and no `fifo_wr_en_o` for those cycles.
  - Expect no lost or duplicated word and grant retained; resumes with the next word.
- Early drop. Req1 gives 2 words then drops valid.
  - Expect GRANT→IDLE after 2 writes; rr_ptr=1; a later req0/req1 contention grants req0 first.
- Reset mid-burst. Assert reset_i low after 2 of 4 words.
  - Expect all outputs at reset values immediately (asynchronous).
  - After release, requester 0 is granted first and `wr_count_o` restarts at 0.
- Counter wrap. Preload by 65535 writes, then one more.
  - Expect `wr_count_o` to go 0xFFFF→0x0000 with the write still performed.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the single TX FIFO write port.
// An owner keeps the port for up to MAX_BURST words, then releases it for
// one IDLE bubble cycle. Write strobe and data to the FIFO are registered.
module fifo_wr_arbiter #(
  parameter  int N_REQ     = 2,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      fifo_full_i,
  input  logic                      fifo_afull_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_wr_data_o,
  output logic                      busy_o,
  output logic [OW-1:0]             owner_o,
  output logic [15:0]               wr_count_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     rr_ptr, owner, pick;
  logic              pick_vld;
  logic [7:0]        burst_cnt;
  logic              stall, xfer, last_word;
  logic [DATA_W-1:0] owner_data;

  // Maps rr_ptr+k back into the requester range.
  function automatic logic [OW-1:0] wrap_idx(input int i);
    return OW'(i % N_REQ);
  endfunction

  // Round-robin search: first valid requester after rr_ptr. The loop runs
  // from the far end so the nearest candidate is assigned last and wins.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid_i[wrap_idx(int'(rr_ptr) + k)]) begin
        pick     = wrap_idx(int'(rr_ptr) + k);
        pick_vld = 1'b1;
      end
    end
  end

  // A write still in flight counts against an almost-full FIFO.
  assign stall      = fifo_full_i | (fifo_afull_i & fifo_wr_en_o);
  assign xfer       = (state == GRANT) & req_valid_i[owner] & ~stall;
  assign last_word  = (burst_cnt == 8'(MAX_BURST - 1));
  assign owner_data = req_data_i[owner*DATA_W +: DATA_W];
  assign busy_o     = (state == GRANT);
  assign owner_o    = owner;

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and ready: only the owner sees ready, and only when not stalled.
  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = GRANT;
      GRANT: begin
        req_ready_o[owner] = ~stall;
        // A stall alone never ends the grant; a dropped valid or a full burst does.
        if (!req_valid_i[owner] || (xfer && last_word)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: owner latch, burst length, round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      owner     <= '0;
      rr_ptr    <= OW'(N_REQ - 1);
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        owner     <= pick;
        burst_cnt <= '0;
      end
    end else begin
      if (xfer) burst_cnt <= burst_cnt + 8'd1;
      if (state_nxt == IDLE) rr_ptr <= owner;
    end
  end

  // Registered write port and running word count; data holds between writes.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fifo_wr_en_o   <= 1'b0;
      fifo_wr_data_o <= '0;
      wr_count_o     <= '0;
    end else begin
      fifo_wr_en_o <= xfer;
      if (xfer) begin
        fifo_wr_data_o <= owner_data;
        wr_count_o     <= wr_count_o + 16'd1;
      end
    end
  end

endmodule
